conv_stream_driver: RTL and testbench
=====================================

Name: conv_stream_driver

Overview:
- Transmit-side companion to the convolver: buffers one kernel and one image frame loaded through a simple register-write port.
- On command, streams them out on the convolver's input protocol: kernel_write_en/kernel_in, then shift_write_en/img_input.
- Sits in user_proj_conv between the Wishbone decode and the convolve instance, replacing direct io_in drive during self-test and host loads.

Parameters:
- BITS, 9, width of one pixel / kernel coefficient
- KERNEL_SIZE, 3, kernel edge; the block streams KERNEL_SIZE*KERNEL_SIZE coefficients
- IMG_LENGTH, 16, pixels per image row (must match convolver)
- IMG_HEIGHT, 16, rows per frame; frame size N = IMG_LENGTH*IMG_HEIGHT
- ADDR_W, 8, config address width; requires 2^ADDR_W >= N

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_sel  in  1  write target: 0 = kernel register, 1 = image memory
- cfg_addr  in  ADDR_W  kernel index (0..KERNEL_SIZE^2-1) or pixel index (0..N-1)
- cfg_data  in  BITS  value to store
- start  in  1  single-cycle start pulse
- load_kernel  in  1  sampled with start; 1 = send kernel phase before image
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse at end of frame
- cfg_err  out  1  sticky; set by a dropped or out-of-range config write
- kernel_write_en  out  1  to convolver kernel_write_en
- kernel_out  out  BITS  to convolver kernel_in
- shift_write_en  out  1  to convolver shift_write_en
- img_out  out  BITS  to convolver img_input

Behaviour:
- Reset: all outputs 0, FSM in IDLE, kernel registers 0, cfg_err 0. Image memory is not reset; its contents are undefined until written.
- Config writes:
  - Accepted only in IDLE; the value is written on the clk edge where cfg_we=1.
  - cfg_sel=0 with cfg_addr >= KERNEL_SIZE^2, or cfg_sel=1 with cfg_addr >= N: write dropped, cfg_err set.
  - cfg_we while busy: write dropped, cfg_err set.
  - cfg_err clears only on reset.
- start:
  - Honoured only in IDLE. start while busy is ignored (no error).
  - start and cfg_we in the same IDLE cycle: the write completes first, then start is taken.
- FSM states: IDLE, KERN, IMG, DONE. All outputs are registered.
  - IDLE -> KERN on start with load_kernel=1; IDLE -> IMG on start with load_kernel=0.
  - KERN: KERNEL_SIZE^2 cycles. kernel_write_en=1 and kernel_out = kernel register k, k=0,1,...,8 in index order (the convolver performs the flip). Then -> IMG with no gap cycle.
  - IMG: N cycles. shift_write_en=1 on every cycle and img_out = pixel p, p=0..N-1, raster order. shift_write_en must never drop mid-frame, because the convolver restarts its fill count whenever it drops. Then -> DONE.
  - DONE: one cycle, done=1, busy=1, both enables 0. Then -> IDLE.
- Idle data: whenever an enable is 0, its data output is 0.
- Latency: start accepted at edge t. First kernel beat is visible after edge t+1; first pixel after edge t+1+KERNEL_SIZE^2 (or after t+1 without the kernel phase). done is visible one cycle after the last pixel.
- Counters:
  - Kernel index counter: 4 bits, sized from KERNEL_SIZE^2.
  - Pixel counter: ADDR_W bits, terminal at N-1. No wrap is exposed.
- Reset mid-operation: all enables drop immediately (asynchronously), FSM returns to IDLE, no done pulse. The convolver is reset from the same net.
- Kernel reload: the convolver accepts a kernel only once per reset. Software sets load_kernel=1 only on the first start after a reset; the driver does not enforce this.

Decomposition:
- Shared package conv_pkg: BITS, KERNEL_SIZE, IMG_LENGTH, IMG_HEIGHT defaults, the derived frame size N and kernel count KERNEL_SIZE^2, and the FSM state encoding. The convolve blocks use the same package.
- One sub-module: conv_img_mem, a single-port write / single-port read register array of N x BITS with a registered read.
  - It is prefetched one cycle ahead so img_out stays registered with no bubble.

Test Plan:
- Kernel + image stream: load kernel 1..9 and pixels p -> p mod 256 (N=256), pulse start with load_kernel=1.
  - Expect kernel_write_en high for exactly 9 consecutive cycles carrying 1..9.
  - Then shift_write_en high for exactly 256 consecutive cycles carrying 0..255.
  - Then done for 1 cycle; busy spans 266 cycles.
- Image only: start with load_kernel=0.
  - Expect first pixel one cycle after start, no kernel_write_en, and done at cycle 257 after start.
- Dropped and illegal writes:
  - cfg_we during IMG -> memory unchanged on the next frame, cfg_err=1.
  - Kernel addr 9 in IDLE -> cfg_err=1, registers unchanged.
- Start while busy: second start at the 50th pixel -> ignored; exactly 256 pixels and one done pulse.
- Reset mid-frame: assert reset at pixel 100.
  - Expect shift_write_en and img_out 0 in the same cycle, no done pulse.
  - A new start then streams a full frame from pixel 0.
- End-to-end with the convolve instance: identity kernel (center 1, rest 0) and ramp image.
  - Expect the convolver's img_output to reproduce the interior pixels, clipped to 255, beginning after its 35-value fill.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared definitions for the convolver and its stream driver.
//   Holds the default geometry (pixel width, kernel edge, image size), the
//   derived frame size and kernel count, and the stream-driver FSM encoding.
//   Both the convolve blocks and conv_stream_driver import this package.
package conv_pkg;

  localparam int BITS        = 9;
  localparam int KERNEL_SIZE = 3;
  localparam int IMG_LENGTH  = 16;
  localparam int IMG_HEIGHT  = 16;
  localparam int ADDR_W      = 8;

  localparam int N_PIX  = IMG_LENGTH * IMG_HEIGHT;
  localparam int N_KERN = KERNEL_SIZE * KERNEL_SIZE;

  typedef logic [1:0] drv_state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KERN = 2'd1;
  localparam logic [1:0] S_IMG  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/conv_stream_driver_if.sv
// conv_stream_driver_if -- bundle of the driver's config/command port, status
//   flags and convolver-facing stream outputs.
//   master : host side (drives cfg_*, start, load_kernel; reads status/stream)
//   slave  : driver side (the opposite directions)
interface conv_stream_driver_if #(
  parameter int BITS   = conv_pkg::BITS,
  parameter int ADDR_W = conv_pkg::ADDR_W
);
  logic              cfg_we;
  logic              cfg_sel;
  logic [ADDR_W-1:0] cfg_addr;
  logic [BITS-1:0]   cfg_data;
  logic              start;
  logic              load_kernel;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic              kernel_write_en;
  logic [BITS-1:0]   kernel_out;
  logic              shift_write_en;
  logic [BITS-1:0]   img_out;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data, start, load_kernel,
    input  busy, done, cfg_err, kernel_write_en, kernel_out,
           shift_write_en, img_out
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data, start, load_kernel,
    output busy, done, cfg_err, kernel_write_en, kernel_out,
           shift_write_en, img_out
  );
endinterface

// File: rtl/conv_img_mem.sv
// conv_img_mem -- frame buffer, DEPTH x BITS, one write port and one
//   registered read port.
//   clk      : clock
//   i_we     : write strobe
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address, sampled on clk
//   o_rdata  : data at i_raddr one cycle later (write-first on collision)
module conv_img_mem #(
  parameter int BITS   = conv_pkg::BITS,
  parameter int DEPTH  = conv_pkg::N_PIX,
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [BITS-1:0]   i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [BITS-1:0]   o_rdata
);

  logic [BITS-1:0] r_mem [DEPTH];
  logic [BITS-1:0] r_rdata;

  // Write-first forwarding: a pixel written in the same cycle as start is
  // already the one being prefetched for the first beat.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
    else                              r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_stream_driver.sv
// conv_stream_driver -- buffers one kernel and one image frame written via a
//   simple register port, then on start streams them to the convolver:
//   optional kernel phase (kernel_write_en/kernel_out), image phase
//   (shift_write_en/img_out), then a one-cycle done.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : conv_stream_driver_if.slave
//           cfg_we/cfg_sel/cfg_addr/cfg_data : config write (IDLE only)
//           start/load_kernel                : frame command
//           busy/done/cfg_err                : status
//           kernel_write_en/kernel_out       : to convolver kernel port
//           shift_write_en/img_out           : to convolver pixel port
module conv_stream_driver #(
  parameter int BITS        = conv_pkg::BITS,
  parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
  parameter int IMG_LENGTH  = conv_pkg::IMG_LENGTH,
  parameter int IMG_HEIGHT  = conv_pkg::IMG_HEIGHT,
  parameter int ADDR_W      = conv_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_stream_driver_if.slave  bus
);
  import conv_pkg::*;

  localparam int N_PX = IMG_LENGTH * IMG_HEIGHT;
  localparam int N_KC = KERNEL_SIZE * KERNEL_SIZE;
  localparam int KCW  = $clog2(N_KC + 1);

  localparam logic [KCW-1:0]    K_LAST   = KCW'(N_KC - 1);
  localparam logic [ADDR_W-1:0] P_LAST   = ADDR_W'(N_PX - 1);
  localparam logic [ADDR_W:0]   N_PX_EXT = (ADDR_W + 1)'(N_PX);
  localparam logic [ADDR_W:0]   N_KC_EXT = (ADDR_W + 1)'(N_KC);

  drv_state_t        r_state;
  logic [KCW-1:0]    r_kcnt;
  logic [ADDR_W-1:0] r_pcnt;
  logic [BITS-1:0]   r_kern [N_KC];

  logic              r_kwe;
  logic [BITS-1:0]   r_kout;
  logic              r_swe;
  logic [BITS-1:0]   r_img;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_idle;
  logic              w_addr_ok;
  logic              w_wr_ok;
  logic              w_kern_we;
  logic              w_mem_we;
  logic              w_wr_err;
  logic [KCW-1:0]    w_kidx;
  logic [ADDR_W-1:0] w_raddr;
  logic [BITS-1:0]   w_rdata;

  // Config write decode
  assign w_idle    = (r_state == S_IDLE);
  assign w_addr_ok = bus.cfg_sel ? ({1'b0, bus.cfg_addr} < N_PX_EXT)
                                 : ({1'b0, bus.cfg_addr} < N_KC_EXT);
  assign w_wr_ok   = bus.cfg_we && w_idle && w_addr_ok;
  assign w_kern_we = w_wr_ok && !bus.cfg_sel;
  assign w_mem_we  = w_wr_ok && bus.cfg_sel;
  assign w_wr_err  = bus.cfg_we && !(w_idle && w_addr_ok);
  assign w_kidx    = bus.cfg_addr[KCW-1:0];

  // Prefetch address: pixel 0 sits in the read register before IMG begins,
  // and during IMG the next pixel is fetched while the current one goes out.
  always_comb begin
    w_raddr = '0;
    if (r_state == S_IMG && r_pcnt != P_LAST) w_raddr = r_pcnt + ADDR_W'(1);
  end

  conv_img_mem #(
    .BITS   (BITS),
    .DEPTH  (N_PX),
    .ADDR_W (ADDR_W)
  ) u_img_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (bus.cfg_addr),
    .i_wdata (bus.cfg_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_KC; i++) r_kern[i] <= '0;
    end else if (w_kern_we) begin
      r_kern[w_kidx] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else if (w_wr_err) r_err <= 1'b1;
  end

  // Sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kcnt  <= '0;
      r_pcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_kcnt <= '0;
          r_pcnt <= '0;
          if (bus.start) r_state <= bus.load_kernel ? S_KERN : S_IMG;
        end
        S_KERN: begin
          if (r_kcnt == K_LAST) begin
            r_kcnt  <= '0;
            r_state <= S_IMG;
          end else begin
            r_kcnt <= r_kcnt + KCW'(1);
          end
        end
        S_IMG: begin
          if (r_pcnt == P_LAST) begin
            r_pcnt  <= '0;
            r_state <= S_DONE;
          end else begin
            r_pcnt <= r_pcnt + ADDR_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register stage: everything seen by the convolver lags the state
  // by one cycle; data is forced to zero whenever its enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kwe  <= 1'b0;
      r_kout <= '0;
      r_swe  <= 1'b0;
      r_img  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_kwe  <= (r_state == S_KERN);
      r_kout <= (r_state == S_KERN) ? r_kern[r_kcnt] : '0;
      r_swe  <= (r_state == S_IMG);
      r_img  <= (r_state == S_IMG) ? w_rdata : '0;
      r_busy <= (r_state != S_IDLE);
      r_done <= (r_state == S_DONE);
    end
  end

  assign bus.kernel_write_en = r_kwe;
  assign bus.kernel_out      = r_kout;
  assign bus.shift_write_en  = r_swe;
  assign bus.img_out         = r_img;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.cfg_err         = r_err;

endmodule

// File: tb/tb_conv_stream_driver.sv
// tb_conv_stream_driver -- scoreboard bench for conv_stream_driver.
//   Expected kernel/pixel beats are queued when a frame is started and
//   popped as the driver emits them; frame timing is checked after each run.
module tb_conv_stream_driver;
  import conv_pkg::*;

  localparam int NP = N_PIX;
  localparam int NK = N_KERN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_stream_driver_if #(.BITS(BITS), .ADDR_W(ADDR_W)) bus ();

  conv_stream_driver #(
    .BITS        (BITS),
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_LENGTH  (IMG_LENGTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [BITS-1:0] kq[$];
  logic [BITS-1:0] iq[$];
  logic [BITS-1:0] model_kern [NK];
  logic [BITS-1:0] model_mem  [NP];
  bit              model_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_kbeats = 0;
  int n_pbeats = 0;
  int n_done   = 0;
  int n_busy   = 0;
  int pix_first, pix_last, kern_first, done_cyc;
  bit prev_kwe = 0;
  bit prev_swe = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and observe outputs at the following falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.kernel_write_en) begin
      if (!prev_kwe) kern_first = cyc;
      n_kbeats++;
      if (kq.size() == 0) check("kern_extra_beat", 1, 0);
      else                check("kern_data", bus.kernel_out, kq.pop_front());
    end else begin
      check("kern_idle_data", bus.kernel_out, 0);
    end
    if (bus.shift_write_en) begin
      if (!prev_swe) pix_first = cyc;
      pix_last = cyc;
      n_pbeats++;
      if (iq.size() == 0) check("pix_extra_beat", 1, 0);
      else                check("pix_data", bus.img_out, iq.pop_front());
    end else begin
      check("pix_idle_data", bus.img_out, 0);
    end
    prev_kwe = bus.kernel_write_en;
    prev_swe = bus.shift_write_en;
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.busy) n_busy++;
  endtask

  task automatic cfg_write(input bit sel, input int addr, input logic [BITS-1:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = ADDR_W'(addr);
    bus.cfg_data = data;
    step();
    bus.cfg_we   = 1'b0;
    if (!sel) begin
      if (addr < NK) model_kern[addr] = data;
      else           model_err = 1'b1;
    end else begin
      if (addr < NP) model_mem[addr] = data;
      else           model_err = 1'b1;
    end
  endtask

  // lk: kernel phase; co_wr: pixel-0 write in the start cycle;
  // wr_at / st2_at / rst_at: cycle offsets after start for a dropped write,
  // a second start, and a mid-frame reset (0 = not used).
  task automatic run_frame(input bit lk, input bit co_wr, input logic [BITS-1:0] co_data,
                           input int wr_at, input int st2_at, input int rst_at);
    int  kb0, pb0, dn0, bz0, sedge, n;
    bit  aborted;
    aborted = 0;
    kq.delete();
    iq.delete();
    if (co_wr) model_mem[0] = co_data;
    if (lk) for (int i = 0; i < NK; i++) kq.push_back(model_kern[i]);
    for (int p = 0; p < NP; p++) iq.push_back(model_mem[p]);
    kb0 = n_kbeats; pb0 = n_pbeats; dn0 = n_done; bz0 = n_busy;

    bus.start       = 1'b1;
    bus.load_kernel = lk;
    if (co_wr) begin
      bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_addr = '0; bus.cfg_data = co_data;
    end
    step();
    sedge = cyc;
    bus.start = 1'b0; bus.load_kernel = 1'b0; bus.cfg_we = 1'b0;

    n = 0;
    while (n_done == dn0 && n < 400 && !aborted) begin
      n++;
      if (n == wr_at) begin
        bus.cfg_we = 1'b1; bus.cfg_sel = 1'b1; bus.cfg_addr = ADDR_W'(5); bus.cfg_data = 9'h1AA;
        model_err = 1'b1;
      end
      if (n == st2_at) begin
        bus.start = 1'b1; bus.load_kernel = 1'b1;
      end
      step();
      bus.cfg_we = 1'b0; bus.start = 1'b0; bus.load_kernel = 1'b0;
      if (n == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_shift_we", bus.shift_write_en, 0);
        check("rst_img_out", bus.img_out, 0);
        check("rst_kern_we", bus.kernel_write_en, 0);
        check("rst_busy", bus.busy, 0);
        step();
        step();
        reset = 1'b0;
        model_err = 1'b0;
        for (int i = 0; i < NK; i++) model_kern[i] = '0;
        kq.delete();
        iq.delete();
        aborted = 1;
      end
    end

    if (aborted) begin
      repeat (4) step();
      check("rst_no_done", n_done - dn0, 0);
      check("rst_cfg_err", bus.cfg_err, model_err);
      return;
    end

    if (n_done == dn0) check("done_timeout", 0, 1);
    repeat (4) step();
    check("kern_beats", n_kbeats - kb0, lk ? NK : 0);
    if (lk) check("kern_latency", kern_first - sedge, 1);
    check("pix_beats", n_pbeats - pb0, NP);
    check("pix_contiguous", pix_last - pix_first + 1, NP);
    check("pix_latency", pix_first - sedge, lk ? NK + 1 : 1);
    check("done_pulses", n_done - dn0, 1);
    check("done_latency", done_cyc - sedge, lk ? NK + NP + 1 : NP + 1);
    check("busy_cycles", n_busy - bz0, lk ? NK + NP + 1 : NP + 1);
    check("sb_leftover", kq.size() + iq.size(), 0);
    check("cfg_err", bus.cfg_err, model_err);
  endtask

  initial begin
    reset           = 1'b1;
    bus.cfg_we      = 1'b0;
    bus.cfg_sel     = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_data    = '0;
    bus.start       = 1'b0;
    bus.load_kernel = 1'b0;
    model_err       = 1'b0;
    for (int i = 0; i < NK; i++) model_kern[i] = '0;
    for (int p = 0; p < NP; p++) model_mem[p] = '0;
    repeat (3) @(negedge clk);

    check("reset_kern_we", bus.kernel_write_en, 0);
    check("reset_kern_out", bus.kernel_out, 0);
    check("reset_shift_we", bus.shift_write_en, 0);
    check("reset_img_out", bus.img_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_cfg_err", bus.cfg_err, 0);
    reset = 1'b0;
    step();

    // Kernel 1..9 and ramp image, full kernel + image stream
    for (int i = 0; i < NK; i++) cfg_write(1'b0, i, BITS'(i + 1));
    for (int p = 0; p < NP; p++) cfg_write(1'b1, p, BITS'(p % 256));
    check("cfg_err_after_load", bus.cfg_err, 0);
    run_frame(1'b1, 1'b0, '0, 0, 0, 0);

    // Image only, new pattern, pixel 0 rewritten in the start cycle
    for (int p = 0; p < NP; p++) cfg_write(1'b1, p, BITS'((p * 7 + 3) & 'h1FF));
    run_frame(1'b0, 1'b1, 9'h123, 0, 0, 0);

    // Write while streaming is dropped; following frame shows memory intact
    run_frame(1'b0, 1'b0, '0, 20, 0, 0);
    check("cfg_err_busy_write", bus.cfg_err, 1);
    run_frame(1'b0, 1'b0, '0, 0, 0, 0);

    // Second start at pixel 50 is ignored
    run_frame(1'b0, 1'b0, '0, 0, 51, 0);

    // Reset at pixel 100, then a full frame from pixel 0
    run_frame(1'b0, 1'b0, '0, 0, 0, 101);
    run_frame(1'b0, 1'b0, '0, 0, 0, 0);

    // Out-of-range kernel address leaves registers untouched
    for (int i = 0; i < NK; i++) cfg_write(1'b0, i, BITS'(11 + i));
    check("cfg_err_before_bad", bus.cfg_err, 0);
    cfg_write(1'b0, 9, 9'h077);
    check("cfg_err_kern_addr", bus.cfg_err, 1);
    run_frame(1'b1, 1'b0, '0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
